// File: rtl/main_memory_block_if.sv
// Block-transfer request/response bus between the cache controller and main memory.
interface main_memory_block_if #(
   parameter int unsigned ADDR_W          = 10,
   parameter int unsigned WORDS_PER_BLOCK = 4
) ();
   localparam int unsigned BLK_W = 32 * WORDS_PER_BLOCK;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [BLK_W-1:0]  wdata;
   logic [BLK_W-1:0]  rdata;
   logic              busy;
   logic              done;

   // Requester side (cache controller)
   modport master (
      output req, we, addr, wdata,
      input  rdata, busy, done
   );

   // Memory side
   modport slave (
      input  req, we, addr, wdata,
      output rdata, busy, done
   );
endinterface

// File: rtl/main_memory_block.sv
// Block-wide main memory with a fixed, programmable access latency and req/done handshake.
// The byte array is not cleared by rst_n; only the control path and rdata are reset.
module main_memory_block #(
   parameter int unsigned ADDR_W          = 10,
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned LATENCY         = 4
) (
   input logic               clk,
   input logic               rst_n,
   main_memory_block_if.slave bus
);
   localparam int unsigned BLK_W     = 32 * WORDS_PER_BLOCK;
   localparam int unsigned OFF_W     = $clog2(WORDS_PER_BLOCK * 4);
   localparam int unsigned IDX_W     = ADDR_W - OFF_W;
   localparam int unsigned MEM_BYTES = 1 << ADDR_W;
   localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [7:0]       mem [0:MEM_BYTES-1] = '{default: 8'h00};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [BLK_W-1:0] rdata_q;

   logic             we_q;
   logic [IDX_W-1:0] blk_q;
   logic [BLK_W-1:0] wdata_q;

   logic             latch_en;
   logic             rd_en;
   logic             wr_en;
   logic [BLK_W-1:0] rd_block;

   // Offset bits inside a block are deliberately ignored (block-aligned access)
   logic             unused_addr_lsbs;
   assign unused_addr_lsbs = ^bus.addr[OFF_W-1:0];

   // State, counter and handshake output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, counter and strobe decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      latch_en = 1'b0;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (bus.req) begin
               latch_en = 1'b1;
               cnt_d    = CNT_W'(LATENCY - 1);
               busy_d   = 1'b1;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            busy_d = 1'b1;
            if (cnt_q == '0) begin
               wr_en   = we_q;
               rd_en   = ~we_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Latched request copies, so the requester may change inputs after acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         blk_q   <= '0;
         wdata_q <= '0;
      end else if (latch_en) begin
         we_q    <= bus.we;
         blk_q   <= bus.addr[ADDR_W-1:OFF_W];
         wdata_q <= bus.wdata;
      end
   end

   // Gather the addressed block from the byte array, little-endian within each word
   always_comb begin
      rd_block = '0;
      for (int w = 0; w < int'(WORDS_PER_BLOCK); w++) begin
         for (int b = 0; b < 4; b++) begin
            rd_block[32*w + 8*b +: 8] = mem[{blk_q, OFF_W'(4*w + b)}];
         end
      end
   end

   // Read data register; holds until the next completed read or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= rd_block;
      end
   end

   // Byte-array commit; no reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int w = 0; w < int'(WORDS_PER_BLOCK); w++) begin
            for (int b = 0; b < 4; b++) begin
               mem[{blk_q, OFF_W'(4*w + b)}] <= wdata_q[32*w + 8*b +: 8];
            end
         end
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_main_memory_block.sv
// Directed bench for main_memory_block: default instance (A) and a LATENCY=1, one-word instance (B).
module tb_main_memory_block;
   logic clk;
   logic rst_a_n;
   logic rst_b_n;
   int   total;
   int   bad;

   main_memory_block_if #(.ADDR_W(10), .WORDS_PER_BLOCK(4)) ifa ();
   main_memory_block_if #(.ADDR_W(10), .WORDS_PER_BLOCK(1)) ifb ();

   main_memory_block #(.ADDR_W(10), .WORDS_PER_BLOCK(4), .LATENCY(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_a_n),
      .bus   (ifa.slave)
   );

   main_memory_block #(.ADDR_W(10), .WORDS_PER_BLOCK(1), .LATENCY(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_b_n),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic get_done(input bit sel);
      return sel ? ifb.done : ifa.done;
   endfunction

   function automatic logic get_busy(input bit sel);
      return sel ? ifb.busy : ifa.busy;
   endfunction

   function automatic logic [127:0] get_rdata(input bit sel);
      return sel ? {96'h0, ifb.rdata} : ifa.rdata;
   endfunction

   // One full transaction; called at a negedge, returns at a negedge with the DUT back in IDLE
   task automatic op(input bit sel, input bit wr, input logic [9:0] a, input logic [127:0] wd,
                     output logic [127:0] rd, output int lat, output int bcnt);
      int cyc;
      if (!sel) begin
         ifa.req = 1'b1; ifa.we = wr; ifa.addr = a; ifa.wdata = wd;
      end else begin
         ifb.req = 1'b1; ifb.we = wr; ifb.addr = a; ifb.wdata = wd[31:0];
      end
      @(negedge clk);
      ifa.req = 1'b0;
      ifb.req = 1'b0;
      cyc  = 0;
      bcnt = 0;
      while (!get_done(sel) && cyc < 20) begin
         if (get_busy(sel)) bcnt++;
         @(negedge clk);
         cyc++;
      end
      lat = cyc;
      rd  = get_rdata(sel);
      @(negedge clk);
      check("done_one_cycle", {127'h0, get_done(sel)}, 128'h0);
   endtask

   localparam logic [127:0] BLK10  = {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344};
   localparam logic [127:0] BLK3F0 = {32'h0BADC0DE, 32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D};
   localparam logic [127:0] BLK20A = {32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
   localparam logic [127:0] BLK20B = {32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12121212, 32'h34343434};
   localparam logic [127:0] BLK30  = {32'h30303033, 32'h30303032, 32'h30303031, 32'h30303030};

   initial begin
      logic [127:0] rd;
      int           lat;
      int           bcnt;
      int           dones;
      int           done_at;

      total = 0;
      bad   = 0;
      ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
      ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy",  {127'h0, ifa.busy}, 128'h0);
      check("rst_done",  {127'h0, ifa.done}, 128'h0);
      check("rst_rdata", ifa.rdata, 128'h0);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      @(negedge clk);

      // Read of untouched block 0
      op(1'b0, 1'b0, 10'h000, '0, rd, lat, bcnt);
      check("rd0_latency", 128'(lat), 128'd4);
      check("rd0_busy_cycles", 128'(bcnt), 128'd4);
      check("rd0_data", rd, 128'h0);

      // Write block 0x010, read back via unaligned 0x01C
      op(1'b0, 1'b1, 10'h010, BLK10, rd, lat, bcnt);
      check("wr10_latency", 128'(lat), 128'd4);
      check("wr10_rdata_unchanged", ifa.rdata, 128'h0);
      op(1'b0, 1'b0, 10'h01C, '0, rd, lat, bcnt);
      check("rd1c_data", rd, BLK10);
      check("byte_010", {120'h0, rd[7:0]}, 128'h44);
      check("byte_013", {120'h0, rd[31:24]}, 128'h11);

      // Last block, then block 0 untouched
      op(1'b0, 1'b1, 10'h3F0, BLK3F0, rd, lat, bcnt);
      check("wr3f0_rdata_hold", ifa.rdata, BLK10);
      op(1'b0, 1'b0, 10'h3FC, '0, rd, lat, bcnt);
      check("rd3f0_data", rd, BLK3F0);
      op(1'b0, 1'b0, 10'h000, '0, rd, lat, bcnt);
      check("rd000_intact", rd, 128'h0);

      // Requests during ACCESS are ignored
      ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 10'h030; ifa.wdata = BLK30;
      dones   = 0;
      done_at = -1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (ifa.done) begin
            dones++;
            done_at = i;
         end
         if (i < 4) begin
            ifa.req   = 1'b1;
            ifa.we    = i[0];
            ifa.addr  = 10'h010;
            ifa.wdata = {4{32'hBAD0BAD0}};
         end else begin
            ifa.req = 1'b0;
         end
      end
      check("ign_done_count", 128'(dones), 128'd1);
      check("ign_done_at", 128'(done_at), 128'd4);
      op(1'b0, 1'b0, 10'h030, '0, rd, lat, bcnt);
      check("ign_rd30", rd, BLK30);
      op(1'b0, 1'b0, 10'h010, '0, rd, lat, bcnt);
      check("ign_rd10", rd, BLK10);

      // Reset during a pending write: commit is lost, no done
      op(1'b0, 1'b1, 10'h020, BLK20A, rd, lat, bcnt);
      ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 10'h020; ifa.wdata = BLK20B;
      @(negedge clk);
      ifa.req = 1'b0;
      @(negedge clk);
      rst_a_n = 1'b0;
      dones = 0;
      repeat (2) begin
         @(negedge clk);
         if (ifa.done) dones++;
      end
      check("mid_rst_busy", {127'h0, ifa.busy}, 128'h0);
      check("mid_rst_rdata", ifa.rdata, 128'h0);
      rst_a_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (ifa.done) dones++;
      end
      check("mid_rst_no_done", 128'(dones), 128'd0);
      op(1'b0, 1'b0, 10'h020, '0, rd, lat, bcnt);
      check("rd20_old", rd, BLK20A);
      op(1'b0, 1'b0, 10'h010, '0, rd, lat, bcnt);
      check("rd10_survives_rst", rd, BLK10);

      // Reset during a pending read leaves rdata cleared
      ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = 10'h3F0;
      @(negedge clk);
      ifa.req = 1'b0;
      @(negedge clk);
      rst_a_n = 1'b0;
      @(negedge clk);
      rst_a_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rd_rst_rdata", ifa.rdata, 128'h0);

      // Minimal instance: LATENCY=1, one word per block
      op(1'b1, 1'b1, 10'h000, 128'hDEADBEEF, rd, lat, bcnt);
      check("b_wr_latency", 128'(lat), 128'd1);
      check("b_wr_rdata_unchanged", {96'h0, ifb.rdata}, 128'h0);
      op(1'b1, 1'b0, 10'h003, '0, rd, lat, bcnt);
      check("b_rd_latency", 128'(lat), 128'd1);
      check("b_rd_busy_cycles", 128'(bcnt), 128'd1);
      check("b_rd_data", rd, 128'hDEADBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
